pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Generic parametrised pipeline stage register that replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a data bundle and a control-flag bundle with valid/ready flow control. A 2-entry skid buffer gives full throughput with registered backpressure. It adds flush (bubble insertion), debug-step gating and a sticky halt capture.

Parameters:
DATA_W, 96, width of data bundle (PC, operands, addresses, register indices); no reset clearing required beyond reset.
CTRL_W, 16, width of control-flag bundle; cleared whenever the entry is invalid (bubble).
HALT_EN, 1, 1 = enable sticky halt capture on control bit HALT_BIT; 0 = halt logic removed.
HALT_BIT, 0, index in i_ctrl of the halt flag; legal range 0..CTRL_W-1.

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  reset, synchronous, active-high
i_step  in  1  debug step enable; 0 freezes all state (flush and transfers ignored)
i_flush  in  1  discard all held entries (branch/jump mispredict, exception)
i_valid  in  1  upstream entry valid
o_ready  out  1  stage can accept; depends only on registered state
i_data  in  DATA_W  upstream data bundle
i_ctrl  in  CTRL_W  upstream control flags
o_valid  out  1  output entry valid
i_ready  in  1  downstream accepts
o_data  out  DATA_W  output data bundle
o_ctrl  out  CTRL_W  output control flags, all-zero when o_valid=0
o_occupancy  out  2  entries held: 0, 1 or 2
o_halted  out  1  sticky: a halt-flagged entry has been accepted

Behaviour:
- Reset (i_rst=1, overrides everything incl. i_step=0): o_valid=0, o_data=0, o_ctrl=0, skid entry cleared, o_occupancy=0, o_halted=0, o_ready=1.
- Internal: main register (drives outputs) + skid register. States EMPTY (occ 0), ONE (occ 1, main valid), TWO (occ 2, main+skid valid).
- accept = i_step & i_valid & o_ready; drain = i_step & o_valid & i_ready.
- o_ready = (state != TWO) & ~o_halted. No combinational path from i_ready or i_valid to o_ready.
- Latency: entry accepted in cycle N appears on outputs in cycle N+1 when the stage is empty. Throughput 1 entry/cycle with i_ready held high.
- Transitions (when i_step=1, i_flush=0):
  EMPTY: accept -> ONE, main <= input. Else stay.
  ONE: accept & drain -> ONE, main <= input. Accept & ~drain -> TWO, skid <= input, main held. ~accept & drain -> EMPTY. Else stay.
  TWO: drain -> ONE, main <= skid, skid cleared. Else stay; no accept is possible since o_ready=0.
- Stability: while o_valid=1 and i_ready=0, o_data and o_ctrl are stable.
- Draining with no replacement: main ctrl <= 0 and o_valid <= 0. Data is held; data value is don't-care while invalid.
- Flush (i_step=1, i_flush=1): next state EMPTY, both ctrl fields zeroed, o_valid=0. A simultaneous accept is discarded. A simultaneous drain still counts as transferred downstream in that cycle. o_halted is not cleared by flush.
- Halt (HALT_EN=1): o_halted <= 1 on the cycle an entry with i_ctrl[HALT_BIT]=1 is accepted, including when that entry is later flushed. Afterwards o_ready=0 until reset. Held entries keep draining normally.
- i_step=0: no register changes. o_ready is still driven from state, but handshakes do not complete.
- Invariant: o_occupancy always equals the state encoding.

Test Plan:
- Reset then stream 8 entries (data 0x10..0x17, ctrl 0x0002) with i_ready=1, i_valid=1 -> outputs appear 1 cycle later in order; occupancy stays 1; o_ready stays 1.
- Fill then stall: i_ready=0 while sending A=0x1, B=0x2 -> occ 2, o_ready=0, o_data=0x1 stable. Raise i_ready -> A then B delivered on consecutive cycles, occ 2->1->0, no loss or duplication.
- Flush in TWO state with i_valid=1 (data 0x3) -> next cycle o_valid=0, o_ctrl=0, occ=0. Entry 0x3 is never emitted; o_ready=1.
- i_step=0 for 5 cycles with i_valid=1, i_ready=1 and occ=1 -> outputs, occupancy and o_halted unchanged. Re-assert i_step -> transfer resumes.
- Halt: send entries with ctrl[0]=0,0,1,0 -> o_halted=1 the cycle after the third entry is accepted. The fourth entry is never accepted; the first three drain; occ ends at 0.
- Reset asserted mid-stall with occ=2 and i_step=0 -> next cycle all outputs at reset values, o_halted=0, o_ready=1.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid, flush, step gating, sticky halt; ports i_clk,i_rst,i_step,i_flush,i_valid/o_ready/i_data/i_ctrl in, o_valid/i_ready/o_data/o_ctrl out, o_occupancy, o_halted
module pipe_stage_skid #(
  parameter int DATA_W   = 96,
  parameter int CTRL_W   = 16,
  parameter int HALT_EN  = 1,
  parameter int HALT_BIT = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_step,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_occupancy,
  output logic              o_halted
);
  logic              main_v, skid_v, halted, accept, drain;
  logic [DATA_W-1:0] main_d, skid_d;
  logic [CTRL_W-1:0] main_c, skid_c;
  always_comb begin
    o_ready     = ~skid_v & ~halted;
    accept      = i_step & i_valid & o_ready;
    drain       = i_step & main_v & i_ready;
    o_valid     = main_v;
    o_data      = main_d;
    o_ctrl      = main_c;
    o_occupancy = {skid_v, main_v & ~skid_v};
    o_halted    = halted;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      halted <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
      main_c <= '0;
      skid_c <= '0;
    end else if (i_step) begin
      if (HALT_EN != 0 && accept && i_ctrl[HALT_BIT]) halted <= 1'b1;
      if (i_flush) begin
        main_v <= 1'b0;
        main_c <= '0;
        skid_v <= 1'b0;
        skid_c <= '0;
      end else if (skid_v) begin
        if (drain) begin
          main_d <= skid_d;
          main_c <= skid_c;
          skid_v <= 1'b0;
          skid_c <= '0;
        end
      end else if (accept && main_v && !drain) begin
        skid_d <= i_data;
        skid_c <= i_ctrl;
        skid_v <= 1'b1;
      end else if (accept) begin
        main_d <= i_data;
        main_c <= i_ctrl;
        main_v <= 1'b1;
      end else if (drain) begin
        main_v <= 1'b0;
        main_c <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed plus random stimulus against a queue-based reference model
module tb_pipe_stage_skid;
  localparam int DW = 96;
  localparam int CW = 16;
  logic          clk = 1'b0;
  logic          rst, step, flush, valid, ready;
  logic [DW-1:0] data;
  logic [CW-1:0] ctrl;
  logic          o_ready, o_valid, o_halted;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_ctrl;
  logic [1:0]    o_occ;
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] q_d[$];
  logic [CW-1:0] q_c[$];
  logic          m_halted;
  always #5 clk = ~clk;
  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .HALT_EN(1), .HALT_BIT(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_step(step), .i_flush(flush),
    .i_valid(valid), .o_ready(o_ready), .i_data(data), .i_ctrl(ctrl),
    .o_valid(o_valid), .i_ready(ready), .o_data(o_data), .o_ctrl(o_ctrl),
    .o_occupancy(o_occ), .o_halted(o_halted)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic s, input logic f, input logic v, input logic rd,
                     input logic [DW-1:0] d, input logic [CW-1:0] c);
    logic exp_rdy, acc, drn;
    @(negedge clk);
    exp_rdy = (q_d.size() < 2) && !m_halted;
    chk("valid", 128'(o_valid), 128'(q_d.size() > 0));
    chk("occ", 128'(o_occ), 128'(q_d.size()));
    chk("ready", 128'(o_ready), 128'(exp_rdy));
    chk("halted", 128'(o_halted), 128'(m_halted));
    chk("ctrl", 128'(o_ctrl), q_c.size() > 0 ? 128'(q_c[0]) : 128'(0));
    if (q_d.size() > 0) chk("data", 128'(o_data), 128'(q_d[0]));
    rst = r; step = s; flush = f; valid = v; ready = rd; data = d; ctrl = c;
    if (r) begin
      q_d.delete();
      q_c.delete();
      m_halted = 1'b0;
    end else if (s) begin
      acc = v && exp_rdy;
      drn = (q_d.size() > 0) && rd;
      if (acc && c[0]) m_halted = 1'b1;
      if (drn) begin
        void'(q_d.pop_front());
        void'(q_c.pop_front());
      end
      if (f) begin
        q_d.delete();
        q_c.delete();
      end else if (acc) begin
        q_d.push_back(d);
        q_c.push_back(c);
      end
    end
  endtask
  initial begin
    rst = 1'b1; step = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0; data = '0; ctrl = '0;
    m_halted = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_data", 128'(o_data), 128'(0));
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 1, 1, DW'(16 + i), 16'h0002);
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 0, DW'(1), 16'h0004);
    cyc(0, 1, 0, 1, 0, DW'(2), 16'h0008);
    cyc(0, 1, 0, 1, 0, DW'(9), 16'h0008);
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 0, DW'(4), 16'h0010);
    cyc(0, 1, 0, 1, 0, DW'(5), 16'h0010);
    cyc(0, 1, 1, 1, 0, DW'(3), 16'h0020);
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 0, DW'(6), 16'h0040);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, DW'(7), 16'h0080);
    cyc(0, 1, 0, 1, 1, DW'(7), 16'h0080);
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 1, DW'(32), 16'h0000);
    cyc(0, 1, 0, 1, 1, DW'(33), 16'h0000);
    cyc(0, 1, 0, 1, 1, DW'(34), 16'h0001);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 1, DW'(35), 16'h0000);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, DW'(40), 16'h0100);
    cyc(0, 1, 0, 1, 0, DW'(41), 16'h0100);
    cyc(1, 0, 0, 1, 0, DW'(42), 16'h0100);
    cyc(0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(99) == 0, $urandom_range(7) != 0, $urandom_range(15) == 0,
          $urandom_range(2) != 0, $urandom_range(3) != 0,
          {$urandom, $urandom, $urandom}, CW'({$urandom} & 32'hfffe) | CW'($urandom_range(31) == 0));
    cyc(0, 1, 0, 0, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
